// File: rtl/ef_gpio8_in_cond.sv
// GPIO input conditioning: two-flop synchroniser, optional per-pin debounce,
// edge detection and sticky per-pin interrupt status feeding irq.
module ef_gpio8_in_cond #(
  parameter int WIDTH = 8,
  parameter int DB_W  = 16
) (
  input  logic             PCLK,
  input  logic             PRESETn,
  input  logic [WIDTH-1:0] io_in,
  input  logic [WIDTH-1:0] db_en,
  input  logic [DB_W-1:0]  db_limit,
  input  logic [WIDTH-1:0] im_rise,
  input  logic [WIDTH-1:0] im_fall,
  input  logic [WIDTH-1:0] im_hi,
  input  logic [WIDTH-1:0] im_lo,
  input  logic [WIDTH-1:0] irq_mask,
  input  logic [WIDTH-1:0] irq_clr,
  output logic [WIDTH-1:0] sync_o,
  output logic [WIDTH-1:0] data_o,
  output logic [WIDTH-1:0] rise_o,
  output logic [WIDTH-1:0] fall_o,
  output logic [WIDTH-1:0] irq_status,
  output logic             irq
);

  logic [WIDTH-1:0] s1_r;
  logic [WIDTH-1:0] s2_r;
  logic [DB_W-1:0]  cnt_r      [WIDTH];
  logic [DB_W-1:0]  cnt_next_s [WIDTH];
  logic [WIDTH-1:0] data_r;
  logic [WIDTH-1:0] data_next_s;
  logic [WIDTH-1:0] rise_r;
  logic [WIDTH-1:0] fall_r;
  logic [WIDTH-1:0] status_r;
  logic [WIDTH-1:0] set_s;
  logic [WIDTH-1:0] status_next_s;

  // Per-pin debounce: a differing level is accepted once its count reaches the limit.
  always_comb begin
    data_next_s = data_r;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_next_s[i] = cnt_r[i];
      if (!db_en[i]) begin
        data_next_s[i] = s2_r[i];
        cnt_next_s[i]  = {DB_W{1'b0}};
      end else if (s2_r[i] == data_r[i]) begin
        cnt_next_s[i]  = {DB_W{1'b0}};
      end else if (cnt_r[i] >= db_limit) begin
        data_next_s[i] = s2_r[i];
        cnt_next_s[i]  = {DB_W{1'b0}};
      end else begin
        cnt_next_s[i]  = cnt_r[i] + DB_W'(1);
      end
    end
  end

  // Sticky status: a set source in the same cycle overrides the clear strobe.
  always_comb begin
    set_s = (rise_r & im_rise) | (fall_r & im_fall) |
            (data_r & im_hi) | (~data_r & im_lo);
    status_next_s = set_s | (status_r & ~irq_clr);
  end

  // Synchroniser, conditioned value, edge pulses and status registers.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      s1_r     <= {WIDTH{1'b0}};
      s2_r     <= {WIDTH{1'b0}};
      data_r   <= {WIDTH{1'b0}};
      rise_r   <= {WIDTH{1'b0}};
      fall_r   <= {WIDTH{1'b0}};
      status_r <= {WIDTH{1'b0}};
      for (int i = 0; i < WIDTH; i++) begin
        cnt_r[i] <= {DB_W{1'b0}};
      end
    end else begin
      s1_r     <= io_in;
      s2_r     <= s1_r;
      data_r   <= data_next_s;
      rise_r   <= data_next_s & ~data_r;
      fall_r   <= ~data_next_s & data_r;
      status_r <= status_next_s;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_r[i] <= cnt_next_s[i];
      end
    end
  end

  assign sync_o     = s2_r;
  assign data_o     = data_r;
  assign rise_o     = rise_r;
  assign fall_o     = fall_r;
  assign irq_status = status_r;
  assign irq        = |(status_r & irq_mask);

endmodule

// File: tb/tb_ef_gpio8_in_cond.sv
// Directed bench for ef_gpio8_in_cond; expected values are hand-computed
// from the edge numbering (edge 0 = first edge sampling a new io_in level).
module tb_ef_gpio8_in_cond;

  logic        PCLK;
  logic        PRESETn;
  logic [7:0]  io_in;
  logic [7:0]  db_en;
  logic [15:0] db_limit;
  logic [7:0]  im_rise, im_fall, im_hi, im_lo, irq_mask, irq_clr;
  logic [7:0]  sync_o, data_o, rise_o, fall_o, irq_status;
  logic        irq;

  int n_vec = 0;
  int n_err = 0;

  ef_gpio8_in_cond #(.WIDTH(8), .DB_W(16)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .io_in(io_in), .db_en(db_en),
    .db_limit(db_limit), .im_rise(im_rise), .im_fall(im_fall),
    .im_hi(im_hi), .im_lo(im_lo), .irq_mask(irq_mask), .irq_clr(irq_clr),
    .sync_o(sync_o), .data_o(data_o), .rise_o(rise_o), .fall_o(fall_o),
    .irq_status(irq_status), .irq(irq)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs are driven and outputs sampled 2 time units later.
  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge PCLK);
      #2;
    end
  endtask

  initial begin
    PRESETn = 1'b0; io_in = 8'h00; db_en = 8'h00; db_limit = 16'd0;
    im_rise = 8'h00; im_fall = 8'h00; im_hi = 8'h00; im_lo = 8'h00;
    irq_mask = 8'h00; irq_clr = 8'h00;
    tick(2);
    chk("rst_sync", 16'(sync_o), 16'h00);
    chk("rst_data", 16'(data_o), 16'h00);
    chk("rst_status", 16'(irq_status), 16'h00);
    chk("rst_irq", 16'(irq), 16'h0);
    PRESETn = 1'b1;
    tick(3);

    // Bypass: 0x00 -> 0xA5
    io_in = 8'hA5;
    tick(1); chk("byp_sync_e0", 16'(sync_o), 16'h00);
    tick(1); chk("byp_sync_e1", 16'(sync_o), 16'hA5);
             chk("byp_data_e1", 16'(data_o), 16'h00);
    tick(1); chk("byp_data_e2", 16'(data_o), 16'hA5);
             chk("byp_rise_e2", 16'(rise_o), 16'hA5);
    tick(1); chk("byp_rise_e3", 16'(rise_o), 16'h00);
             chk("byp_status_e3", 16'(irq_status), 16'h00);
    io_in = 8'h00;
    tick(3); chk("byp_fall_e2", 16'(fall_o), 16'hA5);
             chk("byp_data0_e2", 16'(data_o), 16'h00);
    tick(2);

    // Debounce reject: 3-cycle pulse with L=4
    db_en = 8'hFF; db_limit = 16'd4;
    io_in = 8'h01;
    tick(3);
    io_in = 8'h00;
    for (int k = 0; k < 8; k++) begin
      chk("dbr_data", 16'(data_o), 16'h00);
      chk("dbr_rise", 16'(rise_o), 16'h00);
      tick(1);
    end

    // Debounce accept: hold pin 0, L=4
    io_in = 8'h01;
    tick(6); chk("dba_data_e5", 16'(data_o), 16'h00);
    tick(1); chk("dba_data_e6", 16'(data_o), 16'h01);
             chk("dba_rise_e6", 16'(rise_o), 16'h01);
    tick(1); chk("dba_rise_e7", 16'(rise_o), 16'h00);
             chk("dba_data_e7", 16'(data_o), 16'h01);
    io_in = 8'h00;
    tick(6); chk("dba_fall_e5", 16'(fall_o), 16'h00);
             chk("dba_hold_e5", 16'(data_o), 16'h01);
    tick(1); chk("dba_fall_e6", 16'(fall_o), 16'h01);
             chk("dba_drop_e6", 16'(data_o), 16'h00);
    tick(1); chk("dba_fall_e7", 16'(fall_o), 16'h00);

    // Edge IRQ with write-1-to-clear, bypass
    db_en = 8'h00; db_limit = 16'd0; im_rise = 8'h01; irq_mask = 8'h01;
    tick(2);
    io_in = 8'h01;
    tick(3); chk("eirq_irq_e2", 16'(irq), 16'h0);
    tick(1); chk("eirq_irq_e3", 16'(irq), 16'h1);
             chk("eirq_status_e3", 16'(irq_status), 16'h01);
    irq_clr = 8'h01;
    tick(1); irq_clr = 8'h00;
             chk("eirq_clr_status", 16'(irq_status), 16'h00);
             chk("eirq_clr_irq", 16'(irq), 16'h0);
    io_in = 8'h00;
    tick(4);
    io_in = 8'h01;
    tick(3); chk("eirq_rise_e2", 16'(rise_o), 16'h01);
    irq_clr = 8'h01;
    tick(1); irq_clr = 8'h00;
             chk("eirq_setwins", 16'(irq_status), 16'h01);
    irq_clr = 8'h01;
    tick(1); irq_clr = 8'h00;
             chk("eirq_clr2", 16'(irq_status), 16'h00);
    im_rise = 8'h00; irq_mask = 8'h00;

    // Level IRQ and masking on pin 7 (pin 7 currently low)
    im_lo = 8'h80;
    tick(1); chk("lirq_status", 16'(irq_status), 16'h80);
             chk("lirq_masked", 16'(irq), 16'h0);
    irq_mask = 8'h80;
    #1;      chk("lirq_unmasked", 16'(irq), 16'h1);
    irq_clr = 8'h80;
    tick(1); irq_clr = 8'h00;
             chk("lirq_clr_low", 16'(irq_status), 16'h80);
    io_in = 8'h81;
    tick(3); chk("lirq_data_hi", 16'(data_o), 16'h81);
    irq_clr = 8'h80;
    tick(1); irq_clr = 8'h00;
             chk("lirq_clr_hi", 16'(irq_status), 16'h00);
             chk("lirq_irq_off", 16'(irq), 16'h0);
    im_lo = 8'h00; irq_mask = 8'h00;

    // Reset mid-count: L=10, pin 3 differs for 5 cycles
    db_en = 8'hFF; db_limit = 16'd10;
    io_in = 8'h89;
    tick(7); chk("mrst_pre_data", 16'(data_o), 16'h81);
    PRESETn = 1'b0;
    #1;      chk("mrst_sync", 16'(sync_o), 16'h00);
             chk("mrst_data", 16'(data_o), 16'h00);
             chk("mrst_status", 16'(irq_status), 16'h00);
             chk("mrst_rise_fall", 16'({rise_o, fall_o}), 16'h0000);
    tick(2);
    PRESETn = 1'b1;
    tick(12); chk("mrst_data_e11", 16'(data_o), 16'h00);
              chk("mrst_rise_e11", 16'(rise_o), 16'h00);
    tick(1);  chk("mrst_data_e12", 16'(data_o), 16'h89);
              chk("mrst_rise_e12", 16'(rise_o), 16'h89);
    tick(1);  chk("mrst_rise_e13", 16'(rise_o), 16'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
